// File: rtl/vector_fp_divider_if.sv
// Handshake and data bundle for the vector fixed-point divider.
// The master modport is the producer/consumer side; the slave modport is the divider.
interface vector_fp_divider_if #(
  parameter int DATA_WIDTH = 8,
  parameter int LANES      = 8
);
  // Strict valid/ready: a transfer happens on a rising clk edge where both
  // valid and ready are high; valid and payload stay stable until then.
  logic                             in_valid;
  logic                             in_ready;
  logic [LANES-1:0][DATA_WIDTH-1:0] operand1;
  logic [LANES-1:0][DATA_WIDTH-1:0] operand2;
  logic                             out_valid;
  logic                             out_ready;
  logic [LANES-1:0][DATA_WIDTH-1:0] out;
  logic [LANES-1:0]                 div_by_zero;
  logic [LANES-1:0]                 overflow;
  logic                             busy;
  logic [1:0]                       dbg_state;

  modport master (
    output in_valid, operand1, operand2, out_ready,
    input  in_ready, out_valid, out, div_by_zero, overflow, busy, dbg_state
  );

  modport slave (
    input  in_valid, operand1, operand2, out_ready,
    output in_ready, out_valid, out, div_by_zero, overflow, busy, dbg_state
  );
endinterface

// File: rtl/vector_fp_divider.sv
// Per-lane restoring divider computing (a << FRAC_BITS) / b, one quotient bit per cycle,
// all lanes in lock-step; the result is held until the consumer accepts it.
module vector_fp_divider #(
  parameter int DATA_WIDTH = 8,
  parameter int LANES      = 8,
  parameter int FRAC_BITS  = 10
) (
  input logic                clk,
  input logic                rst,
  vector_fp_divider_if.slave bus
);
  localparam int ITER = DATA_WIDTH + FRAC_BITS;
  localparam int CW   = $clog2(ITER);

  typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, DONE = 2'd2} state_t;

  state_t                           state, state_next;
  logic [CW-1:0]                    count;
  logic [LANES-1:0][ITER-1:0]       div_q;
  logic [LANES-1:0][ITER-1:0]       quo_q, quo_next;
  logic [LANES-1:0][DATA_WIDTH-1:0] dvs_q;
  logic [LANES-1:0][DATA_WIDTH-1:0] rem_q, rem_next;
  logic [LANES-1:0][DATA_WIDTH:0]   rem_shift;
  logic [LANES-1:0][DATA_WIDTH-1:0] res_out;
  logic [LANES-1:0]                 res_dbz, res_ovf;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (bus.in_valid) state_next = RUN;
      RUN:     if (count == CW'(ITER - 1)) state_next = DONE;
      DONE:    if (bus.out_ready) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // The partial remainder is always below the divisor, so it fits DATA_WIDTH bits;
  // only the shifted trial value needs the extra bit.
  always_comb begin
    rem_shift = '0;
    rem_next  = '0;
    quo_next  = '0;
    for (int i = 0; i < LANES; i++) begin
      rem_shift[i] = {rem_q[i], div_q[i][ITER-1]};
      if (rem_shift[i] >= {1'b0, dvs_q[i]}) begin
        rem_next[i] = rem_shift[i][DATA_WIDTH-1:0] - dvs_q[i];
        quo_next[i] = {quo_q[i][ITER-2:0], 1'b1};
      end else begin
        rem_next[i] = rem_shift[i][DATA_WIDTH-1:0];
        quo_next[i] = {quo_q[i][ITER-2:0], 1'b0};
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
      div_q <= '0;
      quo_q <= '0;
      dvs_q <= '0;
      rem_q <= '0;
    end else begin
      case (state)
        IDLE: if (bus.in_valid) begin
          for (int i = 0; i < LANES; i++) begin
            div_q[i] <= {bus.operand1[i], {FRAC_BITS{1'b0}}};
          end
          dvs_q <= bus.operand2;
          rem_q <= '0;
          quo_q <= '0;
          count <= '0;
        end
        RUN: begin
          for (int i = 0; i < LANES; i++) begin
            div_q[i] <= {div_q[i][ITER-2:0], 1'b0};
          end
          rem_q <= rem_next;
          quo_q <= quo_next;
          count <= count + CW'(1);
        end
        default: ;
      endcase
    end
  end

  // Quotient and divisor registers are frozen in DONE, so results derived from them are stable.
  always_comb begin
    res_out = '0;
    res_dbz = '0;
    res_ovf = '0;
    if (state == DONE) begin
      for (int i = 0; i < LANES; i++) begin
        if (dvs_q[i] == '0) begin
          res_out[i] = '1;
          res_dbz[i] = 1'b1;
        end else begin
          res_out[i] = quo_q[i][DATA_WIDTH-1:0];
          res_ovf[i] = |quo_q[i][ITER-1:DATA_WIDTH];
        end
      end
    end
  end

  assign bus.in_ready    = (state == IDLE);
  assign bus.out_valid   = (state == DONE);
  assign bus.busy        = (state != IDLE);
  assign bus.out         = res_out;
  assign bus.div_by_zero = res_dbz;
  assign bus.overflow    = res_ovf;
  assign bus.dbg_state   = state;
endmodule
